// File: rtl/schmitt_pkg.sv
// -----------------------------------------------------------------------------
// schmitt_pkg
// Shared types and default parameter values for the multi-channel Schmitt
// trigger bank.
//   sh_state_e    : per-channel hysteresis state (ST_LOW=0, ST_HIGH=1)
//   DEF_CHANNELS  : default number of channels
//   DEF_DATA_W    : default sample/threshold width
//   DEF_DWELL_W   : default dwell counter width
// -----------------------------------------------------------------------------
package schmitt_pkg;

   typedef enum logic {
      ST_LOW  = 1'b0,
      ST_HIGH = 1'b1
   } sh_state_e;

   localparam int DEF_CHANNELS = 4;
   localparam int DEF_DATA_W   = 8;
   localparam int DEF_DWELL_W  = 4;

endpackage : schmitt_pkg

// File: rtl/schmitt_channel.sv
// -----------------------------------------------------------------------------
// schmitt_channel
// One hysteresis channel: LOW/HIGH state, consecutive-qualifying-sample run
// counter and one-cycle switch pulses.
// Ports:
//   clk, reset    : clock, asynchronous active-high reset
//   sample_valid  : sample is valid this cycle
//   hold          : thresholds invalid; freeze state, clear run, no pulses
//   sample        : unsigned channel sample
//   high_th/low_th: shared rise/fall thresholds
//   dwell         : extra consecutive qualifying samples before switching
//   state_out     : registered state (1 = HIGH)
//   rise_pulse    : one-cycle pulse on LOW->HIGH
//   fall_pulse    : one-cycle pulse on HIGH->LOW
// -----------------------------------------------------------------------------
module schmitt_channel
   import schmitt_pkg::*;
#(
   parameter int DATA_W  = DEF_DATA_W,
   parameter int DWELL_W = DEF_DWELL_W
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               sample_valid,
   input  logic               hold,
   input  logic [DATA_W-1:0]  sample,
   input  logic [DATA_W-1:0]  high_th,
   input  logic [DATA_W-1:0]  low_th,
   input  logic [DWELL_W-1:0] dwell,
   output logic               state_out,
   output logic               rise_pulse,
   output logic               fall_pulse
);

   sh_state_e          state_q, state_d;
   logic [DWELL_W-1:0] cnt_q, cnt_d;
   logic               rise_q, rise_d;
   logic               fall_q, fall_d;
   logic               qualify;

   // Equality with a threshold qualifies; the band between them never does.
   assign qualify = (state_q == ST_LOW) ? (sample >= high_th)
                                        : (sample <= low_th);

   always_comb begin
      // NOTE: every signal written here gets a default first so no path
      // leaves it unassigned, which would otherwise infer a latch.
      state_d = state_q;
      cnt_d   = cnt_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;

      if (hold) begin
         cnt_d = '0;
      end else if (sample_valid) begin
         if (!qualify) begin
            cnt_d = '0;
         end else if (cnt_q >= dwell) begin
            // >= rather than == so a dwell lowered mid-run still switches.
            cnt_d = '0;
            if (state_q == ST_LOW) begin
               state_d = ST_HIGH;
               rise_d  = 1'b1;
            end else begin
               state_d = ST_LOW;
               fall_d  = 1'b1;
            end
         end else begin
            cnt_d = cnt_q + DWELL_W'(1);
         end
      end
   end

   // NOTE: registers use non-blocking assignments so every flop samples the
   // pre-edge value of its inputs regardless of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_LOW;
         cnt_q   <= '0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
      end
   end

   assign state_out  = (state_q == ST_HIGH);
   assign rise_pulse = rise_q;
   assign fall_pulse = fall_q;

endmodule : schmitt_channel

// File: rtl/schmitt_hysteresis_bank.sv
// -----------------------------------------------------------------------------
// schmitt_hysteresis_bank
// Multi-channel digital Schmitt trigger with shared programmable thresholds
// and a dwell filter.
// Ports:
//   clk, reset    : clock, asynchronous active-high reset
//   sample_valid  : all channel samples valid this cycle
//   sample_in     : channel c at [c*DATA_W +: DATA_W]
//   high_th       : rise threshold
//   low_th        : fall threshold
//   dwell         : extra consecutive qualifying samples before switching
//   state_out     : per-channel registered state
//   rise_pulse    : per-channel LOW->HIGH pulse
//   fall_pulse    : per-channel HIGH->LOW pulse
//   th_error      : registered, high while high_th <= low_th
// -----------------------------------------------------------------------------
module schmitt_hysteresis_bank
   import schmitt_pkg::*;
#(
   parameter int CHANNELS = DEF_CHANNELS,
   parameter int DATA_W   = DEF_DATA_W,
   parameter int DWELL_W  = DEF_DWELL_W
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       sample_valid,
   input  logic [CHANNELS*DATA_W-1:0] sample_in,
   input  logic [DATA_W-1:0]          high_th,
   input  logic [DATA_W-1:0]          low_th,
   input  logic [DWELL_W-1:0]         dwell,
   output logic [CHANNELS-1:0]        state_out,
   output logic [CHANNELS-1:0]        rise_pulse,
   output logic [CHANNELS-1:0]        fall_pulse,
   output logic                       th_error
);

   logic th_error_q, th_error_d;

   always_comb begin
      th_error_d = (high_th <= low_th);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         th_error_q <= 1'b0;
      end else begin
         th_error_q <= th_error_d;
      end
   end

   assign th_error = th_error_q;

   // The registered error gates the channels, so a bad threshold pair is
   // honoured one cycle after it appears, matching th_error on the port.
   for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      schmitt_channel #(
         .DATA_W  (DATA_W),
         .DWELL_W (DWELL_W)
      ) u_ch (
         .clk          (clk),
         .reset        (reset),
         .sample_valid (sample_valid),
         .hold         (th_error_q),
         .sample       (sample_in[c*DATA_W +: DATA_W]),
         .high_th      (high_th),
         .low_th       (low_th),
         .dwell        (dwell),
         .state_out    (state_out[c]),
         .rise_pulse   (rise_pulse[c]),
         .fall_pulse   (fall_pulse[c])
      );
   end

endmodule : schmitt_hysteresis_bank

// File: tb/tb_schmitt_hysteresis_bank.sv
// -----------------------------------------------------------------------------
// tb_schmitt_hysteresis_bank
// Directed scenarios followed by randomized stimulus, all checked against a
// behavioural model that tracks, per channel, the logic level and the length
// of the current run of qualifying valid samples.
// -----------------------------------------------------------------------------
module tb_schmitt_hysteresis_bank;

   localparam int CH = 4;
   localparam int DW = 8;
   localparam int WW = 4;

   logic              clk = 1'b0;
   logic              reset;
   logic              sample_valid;
   logic [CH*DW-1:0]  sample_in;
   logic [DW-1:0]     high_th;
   logic [DW-1:0]     low_th;
   logic [WW-1:0]     dwell;
   logic [CH-1:0]     state_out;
   logic [CH-1:0]     rise_pulse;
   logic [CH-1:0]     fall_pulse;
   logic              th_error;

   schmitt_hysteresis_bank #(
      .CHANNELS (CH),
      .DATA_W   (DW),
      .DWELL_W  (WW)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .sample_valid (sample_valid),
      .sample_in    (sample_in),
      .high_th      (high_th),
      .low_th       (low_th),
      .dwell        (dwell),
      .state_out    (state_out),
      .rise_pulse   (rise_pulse),
      .fall_pulse   (fall_pulse),
      .th_error     (th_error)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   bit m_high [CH];   // logic level per channel
   int m_run  [CH];   // consecutive qualifying valid samples so far
   bit m_rise [CH];
   bit m_fall [CH];
   bit m_err;

   function automatic void model_reset();
      for (int c = 0; c < CH; c++) begin
         m_high[c] = 0; m_run[c] = 0; m_rise[c] = 0; m_fall[c] = 0;
      end
      m_err = 0;
   endfunction

   // One rising edge: a channel switches on its (dwell+1)th consecutive
   // qualifying valid sample; the error flag in force is the one registered
   // on the previous edge.
   function automatic void model_clock();
      int s;
      bit q;
      for (int c = 0; c < CH; c++) begin
         m_rise[c] = 0;
         m_fall[c] = 0;
         if (m_err) begin
            m_run[c] = 0;
         end else if (sample_valid) begin
            s = int'(sample_in[c*DW +: DW]);
            q = m_high[c] ? (s <= int'(low_th)) : (s >= int'(high_th));
            if (!q) begin
               m_run[c] = 0;
            end else begin
               m_run[c] = m_run[c] + 1;
               if (m_run[c] >= int'(dwell) + 1) begin
                  if (m_high[c]) m_fall[c] = 1; else m_rise[c] = 1;
                  m_high[c] = !m_high[c];
                  m_run[c]  = 0;
               end
            end
         end
      end
      m_err = (int'(high_th) <= int'(low_th));
   endfunction

   task automatic compare_all(input string tag);
      logic [CH-1:0] es, er, ef;
      for (int c = 0; c < CH; c++) begin
         es[c] = m_high[c]; er[c] = m_rise[c]; ef[c] = m_fall[c];
      end
      check({tag, ".state"}, 32'(state_out),  32'(es));
      check({tag, ".rise"},  32'(rise_pulse), 32'(er));
      check({tag, ".fall"},  32'(fall_pulse), 32'(ef));
      check({tag, ".th_err"}, 32'(th_error),  32'(m_err));
   endtask

   function automatic logic [CH*DW-1:0] pk(int a, int b, int c, int d);
      return {8'(d), 8'(c), 8'(b), 8'(a)};
   endfunction

   // Drive one cycle, let the edge happen, then compare away from the edge.
   task automatic step(input string tag, input bit v, input logic [CH*DW-1:0] s);
      sample_valid = v;
      sample_in    = s;
      @(posedge clk);
      model_clock();
      #1;
      compare_all(tag);
   endtask

   initial begin
      reset        = 1'b1;
      sample_valid = 1'b0;
      sample_in    = '0;
      high_th      = 8'd200;
      low_th       = 8'd50;
      dwell        = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      compare_all("reset");
      reset = 1'b0;

      // dwell=0: first qualifying sample switches, pulse lasts one cycle
      step("t1.a", 1, pk(210, 0, 0, 0));
      check("t1.state0", 32'(state_out[0]), 32'd1);
      check("t1.rise0",  32'(rise_pulse[0]), 32'd1);
      step("t1.b", 0, pk(0, 0, 0, 0));
      check("t1.rise0_drop", 32'(rise_pulse[0]), 32'd0);

      // dwell=2: run broken by 100, switch on the 6th sample
      dwell = 4'd2;
      step("t2.1", 1, pk(120, 210, 0, 0));
      step("t2.2", 1, pk(120, 210, 0, 0));
      step("t2.3", 1, pk(120, 100, 0, 0));
      step("t2.4", 1, pk(120, 210, 0, 0));
      step("t2.5", 1, pk(120, 210, 0, 0));
      check("t2.no_switch", 32'(state_out[1]), 32'd0);
      step("t2.6", 1, pk(120, 210, 0, 0));
      check("t2.rise1", 32'(rise_pulse[1]), 32'd1);

      // ch2 HIGH, dwell=0: band sample ignored, equality with low_th falls
      dwell = 4'd0;
      step("t3.up",  1, pk(120, 120, 210, 0));
      step("t3.120", 1, pk(120, 120, 120, 0));
      check("t3.hold", 32'(state_out[2]), 32'd1);
      step("t3.50",  1, pk(120, 120, 50, 0));
      check("t3.fall2", 32'(fall_pulse[2]), 32'd1);
      step("t3.60",  1, pk(120, 120, 60, 0));
      check("t3.low2", 32'(state_out[2]), 32'd0);

      // dwell=1 run on ch3 with invalid cycles interleaved
      dwell = 4'd1;
      step("t4.1",  1, pk(120, 120, 120, 210));
      step("t4.i1", 0, pk(0, 0, 0, 0));
      step("t4.i2", 0, pk(0, 0, 0, 0));
      step("t4.2",  1, pk(120, 120, 120, 210));
      check("t4.rise3", 32'(rise_pulse[3]), 32'd1);

      // threshold error
      high_th = 8'd50;
      low_th  = 8'd50;
      step("t5.set", 0, pk(0, 0, 0, 0));
      check("t5.err", 32'(th_error), 32'd1);
      for (int i = 0; i < 3; i++) begin
         step("t5.ign", 1, pk(250, 250, 250, 250));
         check("t5.no_rise", 32'(rise_pulse), 32'd0);
      end
      high_th = 8'd200;
      step("t5.clr", 0, pk(0, 0, 0, 0));
      check("t5.err_clr", 32'(th_error), 32'd0);
      step("t5.r1", 1, pk(120, 120, 250, 120));
      check("t5.fresh", 32'(state_out[2]), 32'd0);
      step("t5.r2", 1, pk(120, 120, 250, 120));

      // mid-run asynchronous reset with all channels HIGH
      dwell = 4'd0;
      step("t6.allhi", 1, pk(250, 250, 250, 250));
      dwell = 4'd1;
      step("t6.run", 1, pk(10, 10, 10, 10));
      #2;
      reset = 1'b1;
      #1;
      model_reset();
      check("t6.rst_state", 32'(state_out), 32'd0);
      check("t6.rst_pulse", 32'({rise_pulse, fall_pulse}), 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      step("t6.p1", 1, pk(250, 250, 250, 250));
      check("t6.needs2", 32'(state_out), 32'd0);
      step("t6.p2", 1, pk(250, 250, 250, 250));
      check("t6.switched", 32'(state_out), 32'hF);

      // randomized stimulus
      for (int n = 0; n < 600; n++) begin
         logic [CH*DW-1:0] s;
         if ($urandom_range(0, 15) == 0) begin
            if ($urandom_range(0, 9) == 0) begin
               high_th = 8'($urandom_range(0, 120));
               low_th  = 8'($urandom_range(int'(high_th), 255));
            end else begin
               low_th  = 8'($urandom_range(0, 120));
               high_th = 8'($urandom_range(int'(low_th) + 1, 255));
            end
         end
         if ($urandom_range(0, 19) == 0) dwell = 4'($urandom_range(0, 3));
         for (int c = 0; c < CH; c++) begin
            int v;
            case ($urandom_range(0, 4))
               0:       v = int'(high_th);
               1:       v = int'(low_th);
               2:       v = $urandom_range(int'(high_th), 255);
               3:       v = $urandom_range(0, int'(low_th));
               default: v = $urandom_range(0, 255);
            endcase
            s[c*DW +: DW] = 8'(v);
         end
         step("rand", ($urandom_range(0, 3) != 0), s);
         for (int c = 0; c < CH; c++) begin
            if (rise_pulse[c] && fall_pulse[c]) begin
               check("rand.excl", 32'({rise_pulse[c], fall_pulse[c]}), 32'd0);
            end
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_schmitt_hysteresis_bank
